// File: rtl/riscv_div_unit.sv
// Iterative radix-2 restoring divide/remainder unit (DIVU, DIV, REMU, REM) for the EX stage.
// Define DIV_EARLY_OUT_EN to let divide-by-zero, signed overflow and unsigned /1 finish at accept.
module riscv_div_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [ALU_OP_WIDTH-1:0] operator_i,
  input  logic [DATA_WIDTH-1:0]   op_a_i,
  input  logic [DATA_WIDTH-1:0]   op_b_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [DATA_WIDTH-1:0]   result_o,
  output logic                    busy_o
);

  localparam logic [ALU_OP_WIDTH-3:0] DIV_GROUP = (ALU_OP_WIDTH-2)'(5'b01100);
  localparam logic [DATA_WIDTH-1:0]   LAST_STEP = DATA_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_e;

  state_e                state_q, state_d;
  logic                  op_rem_q, neg_q_q, neg_r_q;
  logic [DATA_WIDTH-1:0] quot_q, divisor_q, rem_q, cnt_q, result_q;

  logic                  op_legal, accept, signed_mode, a_neg, b_neg, take;
  logic [DATA_WIDTH-1:0] abs_a, abs_b, q_fix, r_fix;
  logic [DATA_WIDTH:0]   rem_shift, rem_next;

  assign op_legal    = (operator_i[ALU_OP_WIDTH-1:2] == DIV_GROUP);
  assign accept      = valid_i & (state_q == IDLE) & op_legal & ~flush_i;
  assign signed_mode = operator_i[0];
  assign a_neg       = signed_mode & op_a_i[DATA_WIDTH-1];
  assign b_neg       = signed_mode & op_b_i[DATA_WIDTH-1];
  assign abs_a       = a_neg ? -op_a_i : op_a_i;
  assign abs_b       = b_neg ? -op_b_i : op_b_i;

  // The shifted partial remainder carries one extra bit so the trial subtraction cannot wrap.
  assign rem_shift = {rem_q, quot_q[DATA_WIDTH-1]};
  assign take      = (rem_shift >= {1'b0, divisor_q});
  assign rem_next  = take ? (rem_shift - {1'b0, divisor_q}) : rem_shift;

  assign q_fix = neg_q_q ? -quot_q : quot_q;
  assign r_fix = neg_r_q ? -rem_q : rem_q;

`ifdef DIV_EARLY_OUT_EN
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic                  early_out;
  logic [DATA_WIDTH-1:0] early_q, early_r;

  always_comb begin
    early_out = 1'b0;
    early_q   = op_a_i;
    early_r   = '0;
    if (op_b_i == '0) begin
      early_out = 1'b1;
      early_q   = '1;
      early_r   = op_a_i;
    end else if (signed_mode && op_a_i == MOST_NEG && op_b_i == '1) begin
      early_out = 1'b1;
      early_q   = MOST_NEG;
    end else if (!signed_mode && op_b_i == DATA_WIDTH'(1)) begin
      early_out = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
`ifdef DIV_EARLY_OUT_EN
        state_d = early_out ? DONE : DIV;
`else
        state_d = DIV;
`endif
      end
      DIV:  if (cnt_q == LAST_STEP) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // A zero divisor yields an all-ones quotient whatever the operand signs, so it is never negated.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_rem_q  <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      quot_q    <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_rem_q  <= operator_i[1];
          neg_q_q   <= (a_neg ^ b_neg) & (op_b_i != '0);
          neg_r_q   <= a_neg;
          quot_q    <= abs_a;
          divisor_q <= abs_b;
          rem_q     <= '0;
          cnt_q     <= '0;
`ifdef DIV_EARLY_OUT_EN
          if (early_out) result_q <= operator_i[1] ? early_r : early_q;
`endif
        end
        DIV: begin
          rem_q  <= rem_next[DATA_WIDTH-1:0];
          quot_q <= {quot_q[DATA_WIDTH-2:0], take};
          cnt_q  <= cnt_q + DATA_WIDTH'(1);
        end
        FIX: result_q <= op_rem_q ? r_fix : q_fix;
        default: ;
      endcase
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign busy_o   = (state_q != IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_riscv_div_unit.sv
// Directed scoreboard bench for riscv_div_unit: expected results are queued at issue and popped at valid_o.
module tb_riscv_div_unit;

  localparam logic [6:0] ALU_ADD  = 7'b0011000;
  localparam logic [6:0] ALU_DIVU = 7'b0110000;
  localparam logic [6:0] ALU_DIV  = 7'b0110001;
  localparam logic [6:0] ALU_REMU = 7'b0110010;
  localparam logic [6:0] ALU_REM  = 7'b0110011;
  localparam int FULL_LAT = 34;
`ifdef DIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 34;
`endif

  logic        clk, rst, flush_i, valid_i, ready_o, valid_o, ready_i, busy_o;
  logic [6:0]  operator_i;
  logic [31:0] op_a_i, op_b_i, result_o;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] held;

  riscv_div_unit #(.DATA_WIDTH(32), .ALU_OP_WIDTH(7)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .operator_i(operator_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .valid_o(valid_o),
    .ready_i(ready_i), .result_o(result_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one operation for a single edge; the caller decides what follows.
  task automatic driveOp(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    operator_i = op;
    op_a_i     = a;
    op_b_i     = b;
    valid_i    = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input logic [6:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int   lat;
    logic rdy_seen;
    exp_q.push_back(exp);
    driveOp(op, a, b);
    lat      = 1;
    rdy_seen = 1'b0;
    while (!valid_o && lat < 200) begin
      rdy_seen |= ready_o;
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_rdy_busy"}, {31'd0, rdy_seen}, 32'd0);
    checkOutput({tag, "_res"}, result_o, exp_q.pop_front());
    if (ready_i) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_retire"}, {29'd0, valid_o, ready_o, busy_o}, 32'b010);
    end
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    operator_i = ALU_ADD; op_a_i = '0; op_b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_flags", {29'd0, valid_o, ready_o, busy_o}, 32'b010);
    checkOutput("reset_result", result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd14, FULL_LAT);
    applyStimulus("remu_100_7", ALU_REMU, 32'd100, 32'd7, 32'd2, FULL_LAT);
    applyStimulus("div_m7_2", ALU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, FULL_LAT);
    applyStimulus("rem_m7_2", ALU_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, FULL_LAT);
    applyStimulus("div_7_m2", ALU_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, FULL_LAT);
    applyStimulus("rem_7_m2", ALU_REM, 32'd7, 32'hFFFFFFFE, 32'd1, FULL_LAT);
    applyStimulus("divu_5_0", ALU_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, SPECIAL_LAT);
    applyStimulus("div_5_0", ALU_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, SPECIAL_LAT);
    applyStimulus("remu_5_0", ALU_REMU, 32'd5, 32'd0, 32'd5, SPECIAL_LAT);
    applyStimulus("rem_5_0", ALU_REM, 32'd5, 32'd0, 32'd5, SPECIAL_LAT);
    applyStimulus("div_m7_0", ALU_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, SPECIAL_LAT);
    applyStimulus("rem_m7_0", ALU_REM, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, SPECIAL_LAT);
    applyStimulus("div_ovf", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPECIAL_LAT);
    applyStimulus("rem_ovf", ALU_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, SPECIAL_LAT);
    applyStimulus("divu_by1", ALU_DIVU, 32'h12345678, 32'd1, 32'h12345678, SPECIAL_LAT);
    applyStimulus("remu_by1", ALU_REMU, 32'h12345678, 32'd1, 32'd0, SPECIAL_LAT);
    applyStimulus("divu_big", ALU_DIVU, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, FULL_LAT);

    // Backpressure with a competing request that must be ignored.
    ready_i = 1'b0;
    applyStimulus("bp", ALU_DIVU, 32'd1000, 32'd10, 32'd100, FULL_LAT);
    held = result_o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      operator_i = ALU_DIVU; op_a_i = 32'd9; op_b_i = 32'd3; valid_i = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp_hold", {29'd0, valid_o, ready_o, busy_o}, 32'b101);
      checkOutput("bp_result", result_o, held);
    end
    @(negedge clk);
    valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_retire", {29'd0, valid_o, ready_o, busy_o}, 32'b010);

    // Flush on the tenth DIV cycle.
    driveOp(ALU_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("flush_div", {29'd0, valid_o, ready_o, busy_o}, 32'b010);
    @(negedge clk);
    flush_i = 1'b0;
    applyStimulus("after_flush_div", ALU_DIVU, 32'd9, 32'd3, 32'd3, FULL_LAT);

    // Flush while a result is pending in DONE.
    ready_i = 1'b0;
    applyStimulus("pend", ALU_DIVU, 32'd50, 32'd5, 32'd10, FULL_LAT);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("flush_done", {29'd0, valid_o, ready_o, busy_o}, 32'b010);
    @(negedge clk);
    flush_i = 1'b0; ready_i = 1'b1;
    applyStimulus("after_flush_done", ALU_DIVU, 32'd9, 32'd3, 32'd3, FULL_LAT);

    // Illegal operator must never be accepted.
    @(negedge clk);
    operator_i = ALU_ADD; op_a_i = 32'd1; op_b_i = 32'd1; valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("illegal_op", {29'd0, valid_o, ready_o, busy_o}, 32'b010);
    end
    @(negedge clk);
    valid_i = 1'b0;

    // Reset in the middle of an operation.
    driveOp(ALU_DIVU, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_mid_flags", {29'd0, valid_o, ready_o, busy_o}, 32'b010);
    checkOutput("rst_mid_result", result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("after_rst", ALU_REMU, 32'd100, 32'd7, 32'd2, FULL_LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
